// File: rtl/adc_readout_streamer.sv
// Streams packed 12-bit ADC capture-RAM words as zero-extended 16-bit sample pairs.
// Defining ADC_RDBK_TESTPAT_EN adds iTestPatEn, which substitutes a counting test pattern for RAM data.
module adc_readout_streamer #(
  parameter int RD_LATENCY = 2
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        iDataReady,
  input  logic [15:0] iRecLength,
  output logic        oRdEn,
  output logic [14:0] oRAddr,
  input  logic [63:0] iRamData0,
  input  logic [31:0] iRamData1,
`ifdef ADC_RDBK_TESTPAT_EN
  input  logic        iTestPatEn,
`endif
  output logic [31:0] oStreamData,
  output logic        oStreamValid,
  input  logic        iStreamReady,
  output logic        oStreamLast,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_e;

  state_e      state_q, state_d;
  logic        rdyPrev_q;
  logic        armed_q;
  logic [15:0] len_q, len_d;
  logic [15:0] wordIdx_q, wordIdx_d;
  logic [2:0]  waitCnt_q, waitCnt_d;
  logic [1:0]  beat_q, beat_d;
  logic [95:0] hold_q, hold_d;
  logic [95:0] capWord;
  logic [15:0] nextIdx;
  logic        startEdge;
  logic [11:0] chLo, chHi;

  // Concatenating {D1, D0} places ch0..ch7 in consecutive 12-bit fields.
`ifdef ADC_RDBK_TESTPAT_EN
  logic [95:0] patWord;
  always_comb begin
    patWord = '0;
    for (int n = 0; n < 8; n++) begin
      patWord[12*n +: 12] = {wordIdx_q[8:0], 3'(n)};
    end
  end
  assign capWord = iTestPatEn ? patWord : {iRamData1, iRamData0};
`else
  assign capWord = {iRamData1, iRamData0};
`endif

  assign nextIdx   = wordIdx_q + 16'd1;
  // armed_q blocks a start from a level that was already high when reset released.
  assign startEdge = iDataReady && !rdyPrev_q && armed_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordIdx_d = wordIdx_q;
    waitCnt_d = waitCnt_q;
    beat_d    = beat_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (startEdge) begin
          len_d     = iRecLength[15] ? 16'h8000 : iRecLength;
          wordIdx_d = '0;
          state_d   = (iRecLength == 16'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q == 3'(RD_LATENCY - 1)) begin
          hold_d  = capWord;
          beat_d  = '0;
          state_d = SEND;
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      SEND: begin
        if (iStreamReady) begin
          if (beat_q == 2'd3) begin
            if (nextIdx < len_q) begin
              wordIdx_d = nextIdx;
              state_d   = ISSUE;
            end else begin
              state_d = DONE;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      DONE: begin
        if (!iDataReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rdyPrev_q <= 1'b0;
      armed_q   <= !iDataReady;
      len_q     <= '0;
      wordIdx_q <= '0;
      waitCnt_q <= '0;
      beat_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdyPrev_q <= iDataReady;
      armed_q   <= armed_q || !iDataReady;
      len_q     <= len_d;
      wordIdx_q <= wordIdx_d;
      waitCnt_q <= waitCnt_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    case (beat_q)
      2'd0:    {chHi, chLo} = hold_q[23:0];
      2'd1:    {chHi, chLo} = hold_q[47:24];
      2'd2:    {chHi, chLo} = hold_q[71:48];
      default: {chHi, chLo} = hold_q[95:72];
    endcase
  end

  assign oRdEn        = (state_q == ISSUE);
  assign oRAddr       = wordIdx_q[14:0];
  assign oStreamValid = (state_q == SEND);
  assign oStreamData  = (state_q == SEND) ? {4'b0, chHi, 4'b0, chLo} : 32'd0;
  assign oStreamLast  = (state_q == SEND) && (beat_q == 2'd3) && (nextIdx == len_q);
  assign oBusy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == SEND);
  assign oDone        = (state_q == DONE);

endmodule

// File: doc/adc_readout_streamer.md
ADC_READOUT_STREAMER -- requirements
Module: adc_readout_streamer

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2, meaning capture-RAM read latency in sys_clk cycles (legal values 1..4).
REQ-002 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port iDataReady  input  1  capture-complete level from the ADC capture stage.
REQ-005 SHALL have port iRecLength  input  16  number of capture-RAM words to read.
REQ-006 SHALL have port oRdEn  output  1  capture-RAM read strobe.
REQ-007 SHALL have port oRAddr  output  15  capture-RAM read address.
REQ-008 SHALL have port iRamData0  input  64  capture-RAM low word (samples ch0..ch4 plus ch5[3:0]).
REQ-009 SHALL have port iRamData1  input  32  capture-RAM high word (ch5[11:4], ch6, ch7).
REQ-010 SHALL have port oStreamData  output  32  two 16-bit zero-extended samples per beat.
REQ-011 SHALL have port oStreamValid  output  1  beat valid.
REQ-012 SHALL have port iStreamReady  input  1  sink accepts the beat.
REQ-013 SHALL have port oStreamLast  output  1  marks the final beat of a record.
REQ-014 SHALL have port oBusy  output  1  readout in progress.
REQ-015 SHALL have port oDone  output  1  record fully streamed.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, SEND, DONE.
REQ-017 SHALL leave IDLE only on a rising edge of iDataReady (registered compare); a level already high when reset_n releases SHALL NOT start a readout.
REQ-018 SHALL latch the effective length L = min(iRecLength, 32768) on the start edge; later iRecLength changes SHALL be ignored until the next start.
REQ-019 SHALL go IDLE->DONE directly, with no beats, when L == 0.
REQ-020 SHALL, in ISSUE, assert oRdEn for exactly one cycle with oRAddr = word index k (0..L-1), then enter WAIT.
REQ-021 SHALL count RD_LATENCY cycles in WAIT, then register both RAM words into a 96-bit hold register and enter SEND.
REQ-022 SHALL unpack each RAM word as: ch0 = D0[11:0], ch1 = D0[23:12], ch2 = D0[35:24], ch3 = D0[47:36], ch4 = D0[59:48], ch5 = {D1[7:0], D0[63:60]}, ch6 = D1[19:8], ch7 = D1[31:20].
REQ-023 SHALL emit 4 beats per RAM word; beat j (0..3) SHALL carry {4'b0, ch(2j+1), 4'b0, ch(2j)}.
REQ-024 SHALL advance a beat only when oStreamValid and iStreamReady are both high in the same cycle.
REQ-025 SHALL hold oStreamData, oStreamValid and oStreamLast stable while oStreamValid is high and iStreamReady is low.
REQ-026 SHALL, on acceptance of beat 3, go to ISSUE for k+1 when k+1 < L, else to DONE.
REQ-027 SHALL assert oStreamLast only on beat 3 of word L-1.
REQ-028 SHALL drive oStreamValid low in every state except SEND.
REQ-029 SHALL assert oBusy in ISSUE, WAIT and SEND, and deassert it in IDLE and DONE.
REQ-030 SHALL hold oDone high in DONE and return to IDLE when iDataReady is low.
REQ-031 SHALL ignore iDataReady edges while not in IDLE.
REQ-032 SHALL, if iDataReady falls mid-readout, still complete the current record.

Reset
REQ-033 SHALL, while reset_n is low at a sys_clk edge, enter IDLE and clear oRdEn, oRAddr, oStreamData, oStreamValid, oStreamLast, oBusy, oDone, the counters and the edge-detect register to 0.
REQ-034 SHALL abandon a readout in progress on reset mid-operation, with no further beats emitted.

Configuration
REQ-035 SHALL, with macro ADC_RDBK_TESTPAT_EN defined, add input iTestPatEn (1 bit).
REQ-036 SHALL, with ADC_RDBK_TESTPAT_EN defined and iTestPatEn high, replace chN of word k with (k*8+N) mod 4096.
REQ-037 SHALL, without ADC_RDBK_TESTPAT_EN, omit the iTestPatEn port and always use RAM data.

Verification
REQ-038 SHALL cover: L=3, ready tied high, RAM returns D0=64'h0123456789ABCDEF, D1=32'hFEDCBA98 -> 12 beats; beat0 = 32'h0ABC0DEF, oStreamLast on beat 11, oDone high afterwards.
REQ-039 SHALL cover: L=2, iStreamReady toggled 1-0-0-1 -> data stable while stalled, still 8 beats, no loss or duplication.
REQ-040 SHALL cover: iRecLength=0 -> no oRdEn, no beats, oDone within 2 cycles of the start edge.
REQ-041 SHALL cover: iRecLength=16'hFFFF -> L=32768, last oRAddr=15'h7FFF, no wrap to 0.
REQ-042 SHALL cover: reset_n low during beat 2 of word 5 -> next cycle all outputs 0, state IDLE; a new iDataReady edge restarts at address 0.
REQ-043 SHALL cover: ADC_RDBK_TESTPAT_EN defined, iTestPatEn=1, L=2 -> beats 32'h00010000, 32'h00030002, ..., 32'h000F000E.
